// File: rtl/async_fifo_wr_packer.sv
// Write-side packer for an async FIFO: pairs IN_LEN-bit beats into one
// {last, hi_vld, hi, lo} word and writes it when the FIFO is not full.
module async_fifo_wr_packer #(
  parameter int IN_LEN  = 32,
  parameter int CNT_LEN = 16
) (
  input  logic                  clk_w,
  input  logic                  rstn_w,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_LEN-1:0]     s_data,
  input  logic                  s_last,
  input  logic                  flush,
  input  logic                  fifo_full,
  output logic                  fifo_wen,
  output logic [2*IN_LEN+1:0]   fifo_data,
  output logic [CNT_LEN-1:0]    pkt_cnt,
  output logic                  busy
);

  localparam int W_LEN = 2*IN_LEN+2;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HALF = 1'b1} pack_st_e;

  pack_st_e             state_q, state_d;
  logic [IN_LEN-1:0]    lo_q, lo_d;
  logic                 out_vld_q, out_vld_d;
  logic [W_LEN-1:0]     word_q, word_d;
  logic [CNT_LEN-1:0]   cnt_q, cnt_d;
  logic                 ready_s, wen_s, accept_s, load_s;

  function automatic logic [W_LEN-1:0] pack_word(
    input logic              last,
    input logic              hi_vld,
    input logic [IN_LEN-1:0] hi,
    input logic [IN_LEN-1:0] lo
  );
    return {last, hi_vld, hi, lo};
  endfunction

  // Handshake: the output register can take a new word when empty or draining.
  always_comb begin
    ready_s  = !out_vld_q || !fifo_full;
    wen_s    = out_vld_q && !fifo_full;
    accept_s = s_valid && ready_s;
  end

  // Pack state machine and output word loading.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    word_d  = word_q;
    load_s  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          if (s_last) begin
            word_d = pack_word(1'b1, 1'b0, {IN_LEN{1'b0}}, s_data);
            load_s = 1'b1;
          end else begin
            lo_d    = s_data;
            state_d = ST_HALF;
          end
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HALF: begin
        // An accepted beat always takes priority over flush.
        if (accept_s) begin
          word_d  = pack_word(s_last, 1'b1, s_data, lo_q);
          load_s  = 1'b1;
          lo_d    = {IN_LEN{1'b0}};
          state_d = ST_EMPTY;
        end else if (flush && ready_s) begin
          word_d  = pack_word(1'b0, 1'b0, {IN_LEN{1'b0}}, lo_q);
          load_s  = 1'b1;
          lo_d    = {IN_LEN{1'b0}};
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_HALF;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        lo_d    = {IN_LEN{1'b0}};
      end
    endcase

    if (load_s) begin
      out_vld_d = 1'b1;
    end else begin
      out_vld_d = out_vld_q && !wen_s;
    end

    if (wen_s && word_q[W_LEN-1]) begin
      cnt_d = cnt_q + {{(CNT_LEN-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_w or negedge rstn_w) begin
    if (!rstn_w) begin
      state_q   <= ST_EMPTY;
      lo_q      <= {IN_LEN{1'b0}};
      out_vld_q <= 1'b0;
      word_q    <= {W_LEN{1'b0}};
      cnt_q     <= {CNT_LEN{1'b0}};
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      out_vld_q <= out_vld_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs come straight from the registered word and handshake terms.
  always_comb begin
    s_ready   = ready_s;
    fifo_wen  = wen_s;
    fifo_data = word_q;
    pkt_cnt   = cnt_q;
    busy      = out_vld_q || (state_q == ST_HALF);
  end

endmodule

// File: tb/tb_async_fifo_wr_packer.sv
// Self-checking bench for async_fifo_wr_packer: directed table, corner
// sequences, and a randomized run against a word-queue reference model.
module tb_async_fifo_wr_packer;

  localparam int IN_LEN  = 32;
  localparam int CNT_LEN = 8;

  logic          clk_w = 1'b0;
  logic          rstn_w;
  logic          s_valid, s_ready, s_last, flush, fifo_full, fifo_wen, busy;
  logic [31:0]   s_data;
  logic [65:0]   fifo_data;
  logic [7:0]    pkt_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  async_fifo_wr_packer #(.IN_LEN(IN_LEN), .CNT_LEN(CNT_LEN)) dut (
    .clk_w(clk_w), .rstn_w(rstn_w), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .flush(flush), .fifo_full(fifo_full),
    .fifo_wen(fifo_wen), .fifo_data(fifo_data), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  always #5 clk_w = ~clk_w;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l, f, fu;
    logic        e_rdy, e_wen, e_busy;
    logic [7:0]  e_cnt;
    logic        chk_d;
    logic [65:0] e_data;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [65:0] wd(input logic l, input logic hv,
                                     input logic [31:0] hi, input logic [31:0] lo);
    return {l, hv, hi, lo};
  endfunction

  function automatic vec_t vec(input logic v, input logic [31:0] d, input logic l,
                               input logic f, input logic fu, input logic r,
                               input logic w, input logic b, input logic [7:0] c,
                               input logic cd, input logic [65:0] e);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.f = f; t.fu = fu;
    t.e_rdy = r; t.e_wen = w; t.e_busy = b; t.e_cnt = c; t.chk_d = cd; t.e_data = e;
    return t;
  endfunction

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkw(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l,
                       input logic f, input logic fu);
    s_valid = v; s_data = d; s_last = l; flush = f; fifo_full = fu;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rstn_w = 1'b0;
    @(posedge clk_w); #1;
    rstn_w = 1'b1;
  endtask

  // Reference model: words formed but not yet written, plus an optional held half.
  logic [65:0] mq[$];
  logic        m_half;
  logic [31:0] m_lo;
  logic [7:0]  m_cnt;

  initial begin
    int nw;
    logic m_rdy, m_wen;

    // Directed table; rows applied from reset, outputs checked before each edge.
    tbl[0]  = vec(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 66'h0);
    tbl[1]  = vec(1'b1, 32'hB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 66'h0);
    tbl[2]  = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1,
                  wd(1'b1, 1'b1, 32'hB, 32'hA));
    tbl[3]  = vec(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 66'h0);
    tbl[4]  = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1,
                  wd(1'b1, 1'b0, 32'h0, 32'hC));
    tbl[5]  = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 66'h0);
    tbl[6]  = vec(1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 66'h0);
    tbl[7]  = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 66'h0);
    tbl[8]  = vec(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 66'h0);
    tbl[9]  = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1,
                  wd(1'b0, 1'b0, 32'h0, 32'hD));
    tbl[10] = vec(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 66'h0);
    tbl[11] = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 66'h0);
    tbl[12] = vec(1'b1, 32'hE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 66'h0);
    for (int i = 13; i < 18; i++)
      tbl[i] = vec(1'b1, 32'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1,
                   wd(1'b1, 1'b0, 32'h0, 32'hE));
    tbl[18] = vec(1'b1, 32'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1,
                  wd(1'b1, 1'b0, 32'h0, 32'hE));
    tbl[19] = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1,
                  wd(1'b1, 1'b0, 32'h0, 32'hF));
    tbl[20] = vec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 66'h0);

    // Reset values.
    rstn_w = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_w);
    check1("rst_wen", fifo_wen, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_ready", s_ready, 1'b1);
    checkw("rst_data", fifo_data, 66'h0);
    check8("rst_cnt", pkt_cnt, 8'h0);
    @(posedge clk_w); #1;
    rstn_w = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f, tbl[i].fu);
      @(negedge clk_w);
      check1($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_rdy);
      check1($sformatf("tbl%0d_wen", i), fifo_wen, tbl[i].e_wen);
      check1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check8($sformatf("tbl%0d_cnt", i), pkt_cnt, tbl[i].e_cnt);
      if (tbl[i].chk_d) checkw($sformatf("tbl%0d_data", i), fifo_data, tbl[i].e_data);
      @(posedge clk_w); #1;
    end

    // Continuous 8-beat packet: four writes, last flag on the fourth only.
    apply_reset();
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 32'h100 + 32'(i), (i == 7), 1'b0, 1'b0);
      else       drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_w);
      check1("pk8_ready", s_ready, 1'b1);
      if (fifo_wen) begin
        checkw("pk8_word", fifo_data,
               wd((nw == 3), 1'b1, 32'h100 + 32'(2*nw+1), 32'h100 + 32'(2*nw)));
        nw++;
      end
      @(posedge clk_w); #1;
    end
    checki("pk8_writes", nw, 4);
    check8("pk8_cnt", pkt_cnt, 8'd1);

    // 2^CNT_LEN single-beat packets wrap the packet counter.
    apply_reset();
    nw = 0;
    for (int i = 0; i < 257; i++) begin
      if (i < 256) drive(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      else         drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_w);
      if (fifo_wen) nw++;
      if (i == 256) check8("cnt_pre_wrap", pkt_cnt, 8'hFF);
      @(posedge clk_w); #1;
    end
    @(negedge clk_w);
    checki("wrap_writes", nw, 256);
    check8("cnt_wrapped", pkt_cnt, 8'h00);
    @(posedge clk_w); #1;

    // Reset with a stalled word pending: outputs clear at once, nothing written later.
    apply_reset();
    drive(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    @(posedge clk_w); #1;
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    @(posedge clk_w); #1;
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b1);
    @(negedge clk_w);
    check1("stall_ready", s_ready, 1'b0);
    check1("stall_wen", fifo_wen, 1'b0);
    check8("stall_cnt", pkt_cnt, 8'd1);
    rstn_w = 1'b0;
    #1;
    check1("arst_wen", fifo_wen, 1'b0);
    check1("arst_busy", busy, 1'b0);
    check1("arst_ready", s_ready, 1'b1);
    checkw("arst_data", fifo_data, 66'h0);
    check8("arst_cnt", pkt_cnt, 8'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_w); #1;
    rstn_w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_w);
      check1("post_rst_wen", fifo_wen, 1'b0);
      check1("post_rst_busy", busy, 1'b0);
      @(posedge clk_w); #1;
    end

    // Reset while a half-word is held: a later flush must not write it.
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    @(posedge clk_w); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_w);
    check1("half_busy", busy, 1'b1);
    rstn_w = 1'b0;
    #1;
    check1("half_rst_busy", busy, 1'b0);
    @(posedge clk_w); #1;
    rstn_w = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_w);
      check1("half_rst_wen", fifo_wen, 1'b0);
      @(posedge clk_w); #1;
    end

    // Randomized run against the reference model.
    apply_reset();
    mq.delete();
    m_half = 1'b0;
    m_lo   = 32'h0;
    m_cnt  = 8'h0;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
      @(negedge clk_w);
      m_rdy = (mq.size() == 0) || !fifo_full;
      m_wen = (mq.size() != 0) && !fifo_full;
      check1("rnd_ready", s_ready, m_rdy);
      check1("rnd_wen", fifo_wen, m_wen);
      check1("rnd_busy", busy, (mq.size() != 0) || m_half);
      check8("rnd_cnt", pkt_cnt, m_cnt);
      if (m_wen) begin
        checkw("rnd_data", fifo_data, mq[0]);
        if (mq[0][65]) m_cnt = m_cnt + 8'd1;
        void'(mq.pop_front());
      end
      if (s_valid && m_rdy) begin
        if (m_half) begin
          mq.push_back(wd(s_last, 1'b1, s_data, m_lo));
          m_half = 1'b0;
        end else if (s_last) begin
          mq.push_back(wd(1'b1, 1'b0, 32'h0, s_data));
        end else begin
          m_lo   = s_data;
          m_half = 1'b1;
        end
      end else if (flush && m_half && m_rdy) begin
        mq.push_back(wd(1'b0, 1'b0, 32'h0, m_lo));
        m_half = 1'b0;
      end
      @(posedge clk_w); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
